uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer directly upstream of the UART Tx serializer/FSM.
- Accepts bytes from the host/register interface and presents them first-word-fall-through (FWFT) on P_DATA/data_valid.
- Retires a byte on every cycle the Tx path can accept it (data_valid && !busy), so the host can queue bursts while a frame is being sent.

Parameters:
- DATA_WIDTH, 8, width of each stored word; must match the Tx P_DATA width.
- DEPTH, 8, number of entries; power of two, ≥ 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  host write strobe.
- wr_data  input  DATA_WIDTH  host write byte.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was dropped.
- P_DATA  output  DATA_WIDTH  head-of-FIFO byte to the Tx.
- data_valid  output  1  head byte valid; equals !empty.
- busy  input  1  Tx busy; a byte is consumed when data_valid && !busy.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst), sampled on the rising clk edge.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, data_valid=0, P_DATA=all-ones. Storage array is not reset.
- pop = data_valid && !busy, evaluated combinationally each cycle. The Tx latches P_DATA in that same cycle.
- push = wr_en && (!full || pop).
  - Write when full is accepted only if a pop happens in the same cycle.
  - Otherwise the write is dropped and overflow is set at the next edge.
- overflow: set on any dropped write; cleared only by rst.
- Push: mem[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH, wrapping DEPTH-1 → 0.
- Pop: rd_ptr increments modulo DEPTH.
- count next value:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- full = (count==DEPTH); empty = (count==0). Both are derived from the count register, not combinationally from wr_en/busy.
- FWFT latency: a byte written into an empty FIFO at edge N appears on P_DATA with data_valid=1 after edge N. No same-cycle bypass.
- P_DATA = empty ? all-ones : mem[rd_ptr]. This is a combinational read of registered state and holds the idle-line value while empty.
- Empty with wr_en=1: push only. pop is impossible because data_valid=0.
- busy held high: head byte and data_valid remain stable; writes continue until full.
- busy low for several consecutive cycles: one byte is retired per cycle. Tx/FSM integration raises busy in the cycle after acceptance.
- rst during activity: all contents discarded and all outputs return to reset values at that edge. A wr_en in the reset cycle is ignored and does not set overflow.
- No underflow path: pop is gated by data_valid.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_WIDTH = 8
  - default FIFO depth constant
  - typedef for a UART byte
  - Used by both this block and the Tx top.
- One natural sub-module: uart_fifo_mem, a DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port.
- Pointer/count/flag control stays in uart_tx_fifo.

Test Plan:
- Reset state:
  - Stimulus: assert rst with wr_en=1, wr_data=8'hA5.
  - Required: count=0, empty=1, data_valid=0, P_DATA=8'hFF, overflow=0.
- FWFT latency:
  - Stimulus: busy=1; write 8'h3C at edge N.
  - Required: after N, data_valid=1, P_DATA=8'h3C, count=1. Drop busy for one cycle; then empty=1, P_DATA=8'hFF.
- Fill, overflow, order and wrap:
  - Stimulus: busy=1; write 8'h01..8'h09.
  - Required: full=1 after the 8th write, 9th dropped, overflow=1, count=8.
  - Then busy=0: P_DATA sequence 01..08, one per cycle, ending empty=1.
  - overflow stays 1 until rst.
- Simultaneous push and pop when full:
  - Stimulus: FIFO full with 10..17, wr_en=1, wr_data=8'h55, busy=0 for one cycle.
  - Required: 10 retired, 55 accepted, count stays 8, overflow unchanged.
- Pointer wrap:
  - Stimulus: 20 interleaved single write/pop pairs with values 8'h80+i.
  - Required: every value emerges in order; count never exceeds 1.
- Reset mid-burst:
  - Stimulus: 5 entries queued, assert rst for 1 cycle.
  - Required: count=0, empty=1, overflow=0, and subsequent writes start fresh in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the Tx FIFO and the Tx top.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_FIFO_DEPTH = 8;

  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART Tx serializer.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  // Derived from DEPTH; it sits in the list only because count needs it.
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  input  logic                  busy
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic [AW:0]           count_d;
  logic                  overflow_q;
  logic                  push;
  logic                  pop;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FullCount);
  assign data_valid = !empty;
  assign count      = count_q;
  assign overflow   = overflow_q;
  // Idle-line value while nothing is queued.
  assign P_DATA     = empty ? '1 : mem_rdata;

  always_comb begin
    pop    = data_valid && !busy;
    push   = wr_en && (!full || pop);
    mem_we = push && !rst;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: directed vector table, corner sequences, random vs queue model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  uart_byte_t wr_data = '0;
  logic       busy = 1'b1;
  logic       full, empty, overflow, data_valid;
  logic [3:0] count;
  uart_byte_t p_data;

  int checks = 0;
  int failures = 0;

  uart_byte_t model_q[$];
  logic       model_ovf = 1'b0;

  typedef struct {
    logic       r;
    logic       we;
    uart_byte_t d;
    logic       b;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    uart_byte_t pd;
  } vec_t;

  vec_t vecs[$];

  uart_tx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .P_DATA    (p_data),
    .data_valid(data_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Queue model: pop happens if anything is queued and Tx is free; a write is
  // accepted if there is room, counting the slot freed by a same-cycle pop.
  task automatic model_cycle(input logic r, input logic we, input uart_byte_t d,
                             input logic b);
    bit do_pop;
    if (r) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      do_pop = (model_q.size() > 0) && !b;
      if (do_pop) void'(model_q.pop_front());
      if (we) begin
        if (model_q.size() < Depth) model_q.push_back(d);
        else model_ovf = 1'b1;
      end
    end
  endtask

  task automatic model_compare();
    uart_byte_t head;
    head = (model_q.size() > 0) ? model_q[0] : 8'hFF;
    chk("m_count", 32'(count), 32'(model_q.size()));
    chk("m_empty", 32'(empty), 32'(model_q.size() == 0));
    chk("m_full", 32'(full), 32'(model_q.size() == Depth));
    chk("m_valid", 32'(data_valid), 32'(model_q.size() != 0));
    chk("m_pdata", 32'(p_data), 32'(head));
    chk("m_ovf", 32'(overflow), 32'(model_ovf));
  endtask

  // Drive inputs 1 time unit after an edge, clock once, compare after the edge.
  task automatic step(input logic r, input logic we, input uart_byte_t d, input logic b);
    rst = r;
    wr_en = we;
    wr_data = d;
    busy = b;
    model_cycle(r, we, d, b);
    @(posedge clk);
    #1;
    model_compare();
  endtask

  function automatic vec_t mk(input logic r, input logic we, input uart_byte_t d,
                              input logic b, input int cnt, input logic ovf,
                              input uart_byte_t pd);
    vec_t v;
    v.r = r; v.we = we; v.d = d; v.b = b; v.cnt = cnt;
    v.emp = (cnt == 0); v.ful = (cnt == 8); v.ovf = ovf; v.pd = pd;
    return v;
  endfunction

  initial begin
    uart_byte_t exp_seq[$];
    int max_cnt;

    // Reset with a write pending, FWFT latency, fill/overflow/drain, reset.
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 8'hFF));
    vecs.push_back(mk(0, 1, 8'h3C, 1, 1, 0, 8'h3C));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'hFF));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 8'(i), 1, i, 0, 8'h01));
    vecs.push_back(mk(0, 1, 8'h09, 1, 8, 1, 8'h01));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 8'h00, 0, 8 - k, 1, (k == 8) ? 8'hFF : 8'(k + 1)));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'hFF));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'hFF));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].we, vecs[i].d, vecs[i].b);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].ful));
      chk($sformatf("v%0d_valid", i), 32'(data_valid), 32'(!vecs[i].emp));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_pdata", i), 32'(p_data), 32'(vecs[i].pd));
    end

    // Full FIFO: simultaneous push and pop keeps count at 8, no overflow.
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 1);
    chk("full_before", 32'(full), 32'd1);
    step(0, 1, 8'h55, 0);
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(p_data), 32'h11);
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_order%0d", i), 32'(p_data), 32'(exp_seq[i]));
      step(0, 0, 8'h00, 0);
    end
    chk("pp_empty", 32'(empty), 32'd1);

    // Pointer wrap with single write/pop pairs.
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'(8'h80 + i), 1);
      chk($sformatf("wrap_head%0d", i), 32'(p_data), 32'(8'h80 + i));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      step(0, 0, 8'h00, 0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("wrap_maxcount", 32'(max_cnt), 32'd1);

    // Reset mid-burst, with overflow set first, then fresh writes in order.
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h40 + i), 1);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    chk("mid_count5", 32'(count), 32'd5);
    chk("mid_ovf_set", 32'(overflow), 32'd1);
    step(1, 1, 8'hEE, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_pdata", 32'(p_data), 32'hFF);
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'hA0 + i), 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fresh%0d", i), 32'(p_data), 32'(8'hA0 + i));
      step(0, 0, 8'h00, 0);
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(9) < 6), 8'($urandom()),
           ($urandom_range(1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
